// File: rtl/prf_pkg.sv
// Shared types for the PRF writeback path: register tag width, data width and
// the {prd, data} result entry buffered per functional unit.
package prf_pkg;
  localparam int NUM_PREG = 128;
  localparam int PREG_W   = $clog2(NUM_PREG);
  localparam int XLEN     = 32;

  typedef struct packed {
    logic [PREG_W-1:0] prd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Per-FU result FIFO: circular buffer with occupancy count and synchronous clear.
// Push is ignored when full and pop is ignored when empty.
module wb_fifo
  import prf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  wb_entry_t        din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end
endmodule

// File: rtl/prf_writeback_arbiter.sv
// Shares NUM_WP registered PRF write ports among NUM_REQ functional units via
// per-FU FIFOs and a round-robin grant; the write ports double as wakeup broadcast.
module prf_writeback_arbiter
  import prf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int NUM_WP  = 2,
  parameter int DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][PREG_W-1:0] req_prd,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_WP-1:0]              wr_en,
  output logic [NUM_WP-1:0][PREG_W-1:0]  wr_prd,
  output logic [NUM_WP-1:0][XLEN-1:0]    wr_data,
  output logic                           busy
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_REQ-1:0] full, empty, push, grant;
  wb_entry_t          head     [NUM_REQ];
  wb_entry_t          in_entry [NUM_REQ];
  logic [CNT_W-1:0]   count    [NUM_REQ];
  logic [PTR_W-1:0]   rr_ptr, rr_next, last_idx;
  logic [NUM_WP-1:0]  port_vld;
  wb_entry_t          port_entry [NUM_WP];
  logic               dup_prd;

  // Valid/ready: a result transfers on any edge where req_valid && req_ready;
  // req_ready depends only on registered occupancy, flush and reset, never on
  // req_valid. An x0 result completes the handshake but is dropped here.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign req_ready[g] = reset && !flush && !full[g];
    assign push[g]      = req_valid[g] && req_ready[g] && (req_prd[g] != '0);
    assign in_entry[g]  = '{prd: req_prd[g], data: req_data[g]};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .clear (flush),
      .push  (push[g]),
      .din   (in_entry[g]),
      .pop   (grant[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .head  (head[g]),
      .count (count[g])
    );
  end

  always_comb begin
    busy = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) busy = busy || (count[r] != '0);
  end

  // Scan from rr_ptr with wrap; the k-th non-empty FIFO found lands on port k.
  always_comb begin
    int nport;
    int scan;
    grant    = '0;
    port_vld = '0;
    for (int p = 0; p < NUM_WP; p++) port_entry[p] = '0;
    last_idx = rr_ptr;
    nport    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = int'(rr_ptr) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (r == scan && !empty[r] && nport < NUM_WP && !flush) begin
          grant[r] = 1'b1;
          for (int p = 0; p < NUM_WP; p++) begin
            if (p == nport) begin
              port_vld[p]   = 1'b1;
              port_entry[p] = head[r];
            end
          end
          nport    = nport + 1;
          last_idx = PTR_W'(r);
        end
      end
    end
    if (grant == '0)                         rr_next = rr_ptr;
    else if (last_idx == PTR_W'(NUM_REQ-1)) rr_next = '0;
    else                                     rr_next = last_idx + 1'b1;
  end

  // Tag/data hold their last value on idle ports so wakeup tags stay stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr  <= '0;
      wr_en   <= '0;
      wr_prd  <= '0;
      wr_data <= '0;
    end else begin
      rr_ptr <= flush ? '0 : rr_next;
      wr_en  <= port_vld;
      for (int p = 0; p < NUM_WP; p++) begin
        if (port_vld[p]) begin
          wr_prd[p]  <= port_entry[p].prd;
          wr_data[p] <= port_entry[p].data;
        end
      end
    end
  end

  always_comb begin
    dup_prd = 1'b0;
    for (int a = 0; a < NUM_WP; a++)
      for (int b = a + 1; b < NUM_WP; b++)
        if (wr_en[a] && wr_en[b] && wr_prd[a] == wr_prd[b]) dup_prd = 1'b1;
  end

  a_no_dup_prd: assert property (@(posedge clk) disable iff (!reset) !dup_prd);
endmodule

// File: tb/tb_prf_writeback_arbiter.sv
// Directed bench for prf_writeback_arbiter: per-FU expected queues filled by the
// driver, drained by a monitor on every wr_en, plus cycle-exact directed checks.
module tb_prf_writeback_arbiter;
  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic [2:0]        req_valid;
  logic [2:0][6:0]   req_prd;
  logic [2:0][31:0]  req_data;
  logic [2:0]        req_ready;
  logic [1:0]        wr_en;
  logic [1:0][6:0]   wr_prd;
  logic [1:0][31:0]  wr_data;
  logic              busy;

  int vectors = 0;
  int miscompares = 0;

  logic [38:0] exp_q0[$];
  logic [38:0] exp_q1[$];
  logic [38:0] exp_q2[$];

  logic [2:0][6:0]  tp;
  logic [2:0][31:0] td;
  logic [2:0]       tacc;
  logic [2:0]       saw_low;
  int               next_prd;

  prf_writeback_arbiter #(.NUM_REQ(3), .NUM_WP(2), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_prd   (req_prd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_prd    (wr_prd),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int i, input logic [38:0] e);
    case (i)
      0: exp_q0.push_back(e);
      1: exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  task automatic clear_exp();
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
  endtask

  // driver: present inputs for one cycle, record what the DUT accepts
  task automatic drive(input logic [2:0] v, input logic [2:0][6:0] p,
                       input logic [2:0][31:0] d, output logic [2:0] acc);
    @(posedge clk);
    #1;
    req_valid = v;
    req_prd   = p;
    req_data  = d;
    #2;
    acc = v & req_ready;
    for (int i = 0; i < 3; i++)
      if (acc[i] && p[i] != 7'd0) push_exp(i, {p[i], d[i]});
  endtask

  task automatic idle();
    logic [2:0] a;
    drive(3'b000, '0, '0, a);
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic do_flush();
    @(posedge clk);
    #1;
    req_valid = '0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    clear_exp();
    #2;
    check("flush_wr_en", 64'(wr_en), 64'd0);
    check("flush_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    check("flush_ready_next", 64'(req_ready), 64'b111);
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || wr_en != 2'b00) && n < 60) begin
      tick();
      n++;
    end
    check("drain_in_time", 64'(n < 60), 64'd1);
    tick();
    check("drain_busy", 64'(busy), 64'd0);
    check("drain_queues_empty", 64'(exp_q0.size() + exp_q1.size() + exp_q2.size()), 64'd0);
  endtask

  // monitor: every written port must match the head of some FU's queue
  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        if (wr_en[k]) begin
          logic [38:0] got;
          logic found;
          got = {wr_prd[k], wr_data[k]};
          found = 1'b0;
          if (exp_q0.size() != 0 && exp_q0[0] == got) begin
            void'(exp_q0.pop_front());
            found = 1'b1;
          end else if (exp_q1.size() != 0 && exp_q1[0] == got) begin
            void'(exp_q1.pop_front());
            found = 1'b1;
          end else if (exp_q2.size() != 0 && exp_q2[0] == got) begin
            void'(exp_q2.pop_front());
            found = 1'b1;
          end
          vectors++;
          if (!found) begin
            miscompares++;
            $display("FAIL scoreboard port%0d actual prd=%0d data=%0h required=head of an FU queue",
                     k, wr_prd[k], wr_data[k]);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    req_valid = 3'b111;
    req_prd = '0;
    req_data = '0;

    // 1: reset
    repeat (3) @(posedge clk);
    #3;
    check("reset_ready", 64'(req_ready), 64'b000);
    check("reset_wr_en", 64'(wr_en), 64'b00);
    check("reset_wr_prd", 64'(wr_prd), 64'd0);
    @(posedge clk);
    #1;
    req_valid = '0;
    reset = 1'b1;
    #2;
    check("release_ready", 64'(req_ready), 64'b111);
    check("release_busy", 64'(busy), 64'd0);

    // 2: single ALU result, two-cycle latency
    tp = '0; td = '0;
    tp[0] = 7'd5; td[0] = 32'hDEADBEEF;
    drive(3'b001, tp, td, tacc);
    idle();
    tick();
    check("single_wr_en_c2", 64'(wr_en), 64'b01);
    check("single_prd_c2", 64'(wr_prd[0]), 64'd5);
    check("single_data_c2", 64'(wr_data[0]), 64'hDEADBEEF);
    tick();
    check("single_wr_en_c3", 64'(wr_en), 64'b00);
    check("single_hold_prd", 64'(wr_prd[0]), 64'd5);

    // 3: contention from rr_ptr=0
    do_flush();
    tp[0] = 7'd10; tp[1] = 7'd11; tp[2] = 7'd12;
    td[0] = 32'h0000_0A0A; td[1] = 32'h0000_0B0B; td[2] = 32'h0000_0C0C;
    drive(3'b111, tp, td, tacc);
    check("cont_accept", 64'(tacc), 64'b111);
    idle();
    tick();
    check("cont_wr_en_c2", 64'(wr_en), 64'b11);
    check("cont_prd0_c2", 64'(wr_prd[0]), 64'd10);
    check("cont_prd1_c2", 64'(wr_prd[1]), 64'd11);
    tick();
    check("cont_wr_en_c3", 64'(wr_en), 64'b01);
    check("cont_prd0_c3", 64'(wr_prd[0]), 64'd12);
    check("cont_data0_c3", 64'(wr_data[0]), 64'h0000_0C0C);
    check("cont_rr_ptr", 64'(dut.rr_ptr), 64'd0);

    // 4: backpressure, each FU holds its result until accepted
    next_prd = 20;
    saw_low = '0;
    for (int i = 0; i < 3; i++) begin
      tp[i] = 7'(next_prd);
      td[i] = $urandom;
      next_prd++;
    end
    for (int c = 0; c < 20; c++) begin
      drive(3'b111, tp, td, tacc);
      saw_low = saw_low | ~tacc;
      for (int i = 0; i < 3; i++) begin
        if (tacc[i]) begin
          tp[i] = 7'(next_prd);
          td[i] = $urandom_range(32'hFFFF_FFFF, 0);
          next_prd++;
        end
      end
    end
    idle();
    check("bp_ready_dropped", 64'(saw_low != 3'b000), 64'd1);
    drain();

    // 5: x0 result is accepted but never written
    tp = '0; td = '0;
    td[2] = 32'h1234_5678;
    drive(3'b100, tp, td, tacc);
    check("x0_ready", 64'(req_ready[2]), 64'd1);
    idle();
    check("x0_busy_c1", 64'(busy), 64'd0);
    tick();
    check("x0_wr_en_c2", 64'(wr_en), 64'b00);
    check("x0_busy_c2", 64'(busy), 64'd0);

    // 6a: flush mid-stream
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 3; i++) begin
        tp[i] = 7'(100 + 3 * c + i);
        td[i] = $urandom;
      end
      drive(3'b111, tp, td, tacc);
    end
    idle();
    do_flush();
    tick();
    check("flush_busy", 64'(busy), 64'd0);
    tp = '0;
    tp[0] = 7'd110; td[0] = 32'hCAFE_0110;
    drive(3'b001, tp, td, tacc);
    check("post_flush_accept", 64'(tacc), 64'b001);
    idle();
    drain();

    // 6b: reset mid-stream
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 3; i++) begin
        tp[i] = 7'(111 + 3 * c + i);
        td[i] = $urandom;
      end
      drive(3'b111, tp, td, tacc);
    end
    idle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_exp();
    #2;
    check("midrst_wr_en", 64'(wr_en), 64'b00);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'b000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    check("midrst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    repeat (4) tick();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
